// File: rtl/ruler_ctrl.sv
// ---------------------------------------------------------------------------
// ruler_ctrl
//   Timebase and direction controller for the ruler LED shifter.
//   - Divides clk_i into a one-cycle step strobe (stb_o) every TRIGGER_CNT
//     cycles while running.
//   - Drives the shift direction (dir_o) for the ruler stage.
//   - With RULER_CTRL_BOUNCE_EN defined, it watches the ruler pattern fed
//     back on ruler_i. It reverses direction when the lit bit reaches a
//     corner, which gives a ping-pong sweep, and it counts the reversals
//     in bounce_cnt_o (saturating).
//   - With RULER_CTRL_BOUNCE_EN undefined, ruler_i is ignored. The direction
//     is the dir_sel_i value sampled when the run starts, and bounce_cnt_o
//     stays 0.
//
// Ports
//   clk_i        in   1            system clock, rising edge
//   rst_i        in   1            asynchronous active-high reset
//   en_i         in   1            run enable; low = stopped/idle
//   dir_sel_i    in   1            start direction sampled on IDLE exit (1 = right)
//   ruler_i      in   RULER_WIDTH  current ruler pattern from the ruler stage
//   stb_o        out  1            one-cycle step strobe
//   dir_o        out  1            shift direction (1 = right, 0 = left)
//   bounce_cnt_o out  8            reversals since leaving IDLE, saturating
//
// Configuration macro: RULER_CTRL_BOUNCE_EN (corner detection + bounce count)
// ---------------------------------------------------------------------------
module ruler_ctrl #(
  parameter int TRIGGER_CNT = 50000000,
  parameter int CNT_W       = 26,
  parameter int RULER_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   dir_sel_i,
  input  logic [RULER_WIDTH-1:0] ruler_i,
  output logic                   stb_o,
  output logic                   dir_o,
  output logic [7:0]             bounce_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_R = 2'd1,
    RUN_L = 2'd2
  } state_t;

  // Terminal value of the prescaler. The wrap happens on this value, so the
  // strobe period is exactly TRIGGER_CNT cycles.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TRIGGER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

`ifdef RULER_CTRL_BOUNCE_EN
  // Corner patterns: only the LSB is lit (right end) or only the MSB is lit (left end).
  localparam logic [RULER_WIDTH-1:0] CORNER_R = {{(RULER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RULER_WIDTH-1:0] CORNER_L = {1'b1, {(RULER_WIDTH-1){1'b0}}};

  // Saturating increment for the reversal counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'h01;
    end
  endfunction
`else
  // In this build the pattern feedback is intentionally unused.
  logic unused_ruler;
  assign unused_ruler = ^ruler_i;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             stb_r;
  logic             dir_r;
  logic [7:0]       bounce_r;

  // Control FSM, prescaler and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      stb_r    <= 1'b0;
      dir_r    <= 1'b1;
      bounce_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= CNT_ZERO;
          stb_r <= 1'b0;
          if (en_i) begin
            state_r  <= dir_sel_i ? RUN_R : RUN_L;
            dir_r    <= dir_sel_i;
            bounce_r <= 8'h00;
          end else begin
            state_r  <= IDLE;
          end
        end

        RUN_R, RUN_L: begin
          if (!en_i) begin
            // Stopping takes priority over both the terminal count and a corner.
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            stb_r   <= 1'b0;
          end else begin
            if (cnt_r == CNT_TERM) begin
              cnt_r <= CNT_ZERO;
              stb_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
              stb_r <= 1'b0;
            end
`ifdef RULER_CTRL_BOUNCE_EN
            // Corners are checked every cycle, independent of the strobe.
            // Zero or multi-bit patterns never match, so the direction holds.
            if ((state_r == RUN_R) && (ruler_i == CORNER_R)) begin
              state_r  <= RUN_L;
              dir_r    <= 1'b0;
              bounce_r <= sat_inc8(bounce_r);
            end else if ((state_r == RUN_L) && (ruler_i == CORNER_L)) begin
              state_r  <= RUN_R;
              dir_r    <= 1'b1;
              bounce_r <= sat_inc8(bounce_r);
            end else begin
              state_r  <= state_r;
            end
`else
            state_r  <= state_r;
            bounce_r <= 8'h00;
`endif
          end
        end

        default: begin
          state_r  <= IDLE;
          cnt_r    <= CNT_ZERO;
          stb_r    <= 1'b0;
          dir_r    <= 1'b1;
          bounce_r <= 8'h00;
        end
      endcase
    end
  end

  assign stb_o        = stb_r;
  assign dir_o        = dir_r;
  assign bounce_cnt_o = bounce_r;

endmodule

// File: tb/tb_ruler_ctrl.sv
module tb_ruler_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       dir_sel_i;
  logic [7:0] ruler_i;
  logic       stb_o;
  logic       dir_o;
  logic [7:0] bounce_cnt_o;

  ruler_ctrl #(.TRIGGER_CNT(T), .CNT_W(26), .RULER_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_sel_i(dir_sel_i),
    .ruler_i(ruler_i), .stb_o(stb_o), .dir_o(dir_o), .bounce_cnt_o(bounce_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stb;
    logic       dir;
    logic [7:0] bounce;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes_seen = 0;

  // Reference model: cycles elapsed since the run started, plus direction and bounce count.
  bit running   = 1'b0;
  int phase     = 0;
  bit m_dir     = 1'b1;
  int m_bounce  = 0;

`ifdef RULER_CTRL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  // Monitor: each cycle the DUT presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (stb_o === 1'b1) strobes_seen++;
        if (stb_o !== e.stb || dir_o !== e.dir || bounce_cnt_o !== e.bounce) begin
          errors++;
          $display("FAIL cycle_out t=%0t: got stb=%0d dir=%0d bounce=%0d, expected stb=%0d dir=%0d bounce=%0d",
                   $time, stb_o, dir_o, bounce_cnt_o, e.stb, e.dir, e.bounce);
        end
      end
    end
  end

  // Apply one cycle of inputs, predict the outputs after the next edge, and advance.
  task automatic step(input bit en, input bit dsel, input logic [7:0] ruler);
    exp_t e;
    bit   stb;
    en_i = en; dir_sel_i = dsel; ruler_i = ruler;
    stb = 1'b0;
    if (!running) begin
      if (en) begin
        running  = 1'b1;
        phase    = 0;
        m_dir    = dsel;
        m_bounce = 0;
      end
    end else if (!en) begin
      running = 1'b0;
    end else begin
      phase = phase + 1;
      stb   = (phase % T) == 0;
      if (BOUNCE) begin
        if ((m_dir && ruler == 8'h01) || (!m_dir && ruler == 8'h80)) begin
          m_dir = !m_dir;
          if (m_bounce < 255) m_bounce = m_bounce + 1;
        end
      end
    end
    e.stb = stb; e.dir = m_dir; e.bounce = 8'(m_bounce);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges; its effect must be visible before any clock edge.
  task automatic async_reset();
    rst_i = 1'b1;
    #1;
    checks++;
    if (stb_o !== 1'b0 || dir_o !== 1'b1 || bounce_cnt_o !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got stb=%0d dir=%0d bounce=%0d, expected stb=0 dir=1 bounce=0",
               stb_o, dir_o, bounce_cnt_o);
    end
    running = 1'b0; m_dir = 1'b1; m_bounce = 0; phase = 0;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  function automatic logic [7:0] rand_ruler();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0:       rand_ruler = 8'h01;
      1:       rand_ruler = 8'h80;
      2:       rand_ruler = 8'h00;
      3:       rand_ruler = 8'($urandom);
      default: rand_ruler = 8'h01 << $urandom_range(0, 7);
    endcase
  endfunction

  initial begin
    int base_strobes;
    rst_i = 1'b1; en_i = 1'b0; dir_sel_i = 1'b1; ruler_i = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 20; i++) step(1'b0, $urandom_range(0, 1), 8'($urandom));

    // Start to the right; strobes land every T cycles.
    base_strobes = strobes_seen;
    step(1'b1, 1'b1, 8'h10);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 8'h10);
    checks++;
    if (strobes_seen - base_strobes != 3) begin
      errors++;
      $display("FAIL strobe_count: got %0d strobes, expected 3", strobes_seen - base_strobes);
    end

    // Walk toward the right corner, then bounce back off the left corner.
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h80);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h40);

    // Stop on the terminal-count cycle, then restart to the left.
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h08);

    // Stopping on a corner cycle: the stop wins.
    step(1'b0, 1'b0, 8'h80);
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h01);

    // Build up some bounces, then reset mid-count.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, (i % 2 == 0) ? 8'h80 : 8'h01);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h01);

    // Saturation of the bounce counter.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h80);

    // Fixed-direction run with the corner pattern present.
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h01);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 1), rand_ruler());
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    step(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
